// File: rtl/key_repeat_pulse_pkg.sv
// key_repeat_pulse_pkg: FSM state encodings and default timing constants shared by the key-repeat logic and the set-mode path
package key_repeat_pulse_pkg;
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_DB_PRESS   = 3'd1;
  localparam logic [2:0] S_HOLD       = 3'd2;
  localparam logic [2:0] S_REPEAT     = 3'd3;
  localparam logic [2:0] S_DB_RELEASE = 3'd4;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES     = 16;
  localparam int DEF_REPEAT_CYCLES   = 4;
  localparam int DEF_CNT_WIDTH       = 8;
endpackage

// File: rtl/key_repeat_pulse_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer; i_clock, i_reset (sync active-high), i_d async in, o_q synchronized out
module sync_2ff (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;
  always_ff @(posedge i_clock)
    if (i_reset) {r_q, r_meta} <= 2'b00;
    else {r_q, r_meta} <= {r_meta, i_d};
  assign o_q = r_q;
endmodule

// File: rtl/key_repeat_pulse.sv
// key_repeat_pulse: debounced press/hold/auto-repeat strobe; i_clock, i_reset, i_key (raw async), i_repeat_en -> o_pulse (1-cycle strobe), o_pressed (debounced level)
module key_repeat_pulse
  import key_repeat_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_pulse,
  output logic o_pressed
);
  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
  logic                 w_key_s;
  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_pulse;
  logic                 r_pressed;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  sync_2ff u_sync (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_d    (i_key),
    .o_q    (w_key_s)
  );
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_pressed <= 1'b0;
          r_cnt     <= '0;
          if (w_key_s) r_state <= S_DB_PRESS;
        end
        S_DB_PRESS:
          if (!w_key_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= S_HOLD;
            r_cnt     <= '0;
            r_pulse   <= 1'b1;
            r_pressed <= 1'b1;
          end else r_cnt <= w_cnt_inc;
        S_HOLD:
          if (!w_key_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            // with repeat disabled the count parks here until enabled or released
            if (i_repeat_en) begin
              r_state <= S_REPEAT;
              r_cnt   <= '0;
              r_pulse <= 1'b1;
            end
          end else r_cnt <= w_cnt_inc;
        S_REPEAT:
          if (!w_key_s) begin
            r_state <= S_DB_RELEASE;
            r_cnt   <= '0;
          end else if (!i_repeat_en) begin
            r_state <= S_HOLD;
            r_cnt   <= HOLD_LAST;
          end else if (r_cnt == REP_LAST) begin
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end else r_cnt <= w_cnt_inc;
        S_DB_RELEASE:
          if (w_key_s) begin
            // release bounce: still held, restart the hold delay without a new pulse
            r_state <= S_HOLD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else r_cnt <= w_cnt_inc;
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end
  assign o_pulse   = r_pulse;
  assign o_pressed = r_pressed;
endmodule

// File: tb/tb_key_repeat_pulse.sv
// tb_key_repeat_pulse: directed bench for key_repeat_pulse (default and 1/1/1 parameter instances)
module tb_key_repeat_pulse;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key = 1'b0;
  logic repeat_en = 1'b1;
  logic pulse, pressed, pulse2, pressed2;
  int   passed = 0;
  int   total = 0;
  int   pe[$];
  int   pe2[$];
  logic ph [0:127];
  logic ph2 [0:127];
  always #5 clk = ~clk;
  key_repeat_pulse u_dut (
    .i_clock(clk), .i_reset(rst), .i_key(key), .i_repeat_en(repeat_en),
    .o_pulse(pulse), .o_pressed(pressed)
  );
  key_repeat_pulse #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(1), .REPEAT_CYCLES(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_key(key), .i_repeat_en(repeat_en),
    .o_pulse(pulse2), .o_pressed(pressed2)
  );
  task automatic run(input int hold_len, input logic [15:0] tail, input logic rep, input int rst_edge, input int len);
    pe.delete();
    pe2.delete();
    repeat_en = rep;
    for (int n = 1; n <= len; n++) begin
      key = (n <= hold_len) ? 1'b1 : ((n - hold_len <= 16) ? tail[n - hold_len - 1] : 1'b0);
      rst = (n == rst_edge);
      @(posedge clk);
      #1;
      if (pulse) pe.push_back(n);
      if (pulse2) pe2.push_back(n);
      ph[n] = pressed;
      ph2[n] = pressed2;
    end
    key = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    key = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (pulse !== 1'b0) $display("FAIL reset_pulse got %b want 0", pulse); else passed++;
    total++; if (pressed !== 1'b0) $display("FAIL reset_pressed got %b want 0", pressed); else passed++;
    total++; if (pulse2 !== 1'b0) $display("FAIL reset_pulse_c got %b want 0", pulse2); else passed++;
    total++; if (pressed2 !== 1'b0) $display("FAIL reset_pressed_c got %b want 0", pressed2); else passed++;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic test_single_press;
    run(10, 16'h0000, 1'b1, 0, 30);
    total++; if (pe.size() != 1 || pe[0] != 7) $display("FAIL single_pulse got n=%0d first=%0d want n=1 at 7", pe.size(), pe.size() ? pe[0] : -1); else passed++;
    total++; if (ph[6] !== 1'b0) $display("FAIL single_pressed6 got %b want 0", ph[6]); else passed++;
    total++; if (ph[7] !== 1'b1) $display("FAIL single_pressed7 got %b want 1", ph[7]); else passed++;
    total++; if (ph[16] !== 1'b1) $display("FAIL single_pressed16 got %b want 1", ph[16]); else passed++;
    total++; if (ph[17] !== 1'b0) $display("FAIL single_pressed17 got %b want 0", ph[17]); else passed++;
    total++; if (pe2.size() != 9) $display("FAIL corner_count got %0d want 9", pe2.size()); else passed++;
    total++; if (pe2.size() == 0 || pe2[0] != 4) $display("FAIL corner_first got %0d want 4", pe2.size() ? pe2[0] : -1); else passed++;
    total++; if (pe2.size() == 0 || pe2[pe2.size()-1] != 12) $display("FAIL corner_last got %0d want 12", pe2.size() ? pe2[pe2.size()-1] : -1); else passed++;
    total++; if (ph2[13] !== 1'b1 || ph2[14] !== 1'b0) $display("FAIL corner_pressed got %b%b want 10", ph2[13], ph2[14]); else passed++;
  endtask
  task automatic test_repeat;
    int exp_q[$];
    exp_q = '{7, 23, 27, 31, 35, 39};
    run(40, 16'h0000, 1'b1, 0, 60);
    total++; if (pe.size() != 6) $display("FAIL repeat_count got %0d want 6", pe.size()); else passed++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= pe.size() || pe[i] != exp_q[i]) $display("FAIL repeat_edge%0d got %0d want %0d", i, i < pe.size() ? pe[i] : -1, exp_q[i]);
      else passed++;
    end
    total++; if (ph[46] !== 1'b1 || ph[47] !== 1'b0) $display("FAIL repeat_release got %b%b want 10", ph[46], ph[47]); else passed++;
  endtask
  task automatic test_no_repeat;
    run(40, 16'h0000, 1'b0, 0, 60);
    total++; if (pe.size() != 1 || pe[0] != 7) $display("FAIL norep_pulse got n=%0d first=%0d want n=1 at 7", pe.size(), pe.size() ? pe[0] : -1); else passed++;
    total++; if (pe2.size() != 1 || pe2[0] != 4) $display("FAIL norep_corner got n=%0d first=%0d want n=1 at 4", pe2.size(), pe2.size() ? pe2[0] : -1); else passed++;
    repeat_en = 1'b1;
  endtask
  task automatic test_bounce;
    int highs;
    highs = 0;
    run(0, 16'h0055, 1'b1, 0, 30);
    for (int n = 1; n <= 30; n++) if (ph[n] === 1'b1) highs++;
    total++; if (pe.size() != 0) $display("FAIL bounce_pulse got %0d want 0", pe.size()); else passed++;
    total++; if (highs != 0) $display("FAIL bounce_pressed got %0d high cycles want 0", highs); else passed++;
  endtask
  task automatic test_release_bounce;
    int falls;
    falls = 0;
    run(10, 16'h0002, 1'b1, 0, 35);
    for (int n = 2; n <= 35; n++) if (ph[n-1] === 1'b1 && ph[n] === 1'b0) falls++;
    total++; if (pe.size() != 1 || pe[0] != 7) $display("FAIL relb_pulse got n=%0d first=%0d want n=1 at 7", pe.size(), pe.size() ? pe[0] : -1); else passed++;
    total++; if (falls != 1) $display("FAIL relb_falls got %0d want 1", falls); else passed++;
    total++; if (ph[18] !== 1'b1 || ph[19] !== 1'b0) $display("FAIL relb_release got %b%b want 10", ph[18], ph[19]); else passed++;
  endtask
  task automatic test_reset_mid;
    int exp_q[$];
    exp_q = '{7, 23, 32};
    run(45, 16'h0000, 1'b1, 25, 70);
    total++; if (ph[25] !== 1'b0) $display("FAIL rstmid_pressed got %b want 0", ph[25]); else passed++;
    total++; if (pe.size() != 3) $display("FAIL rstmid_count got %0d want 3", pe.size()); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= pe.size() || pe[i] != exp_q[i]) $display("FAIL rstmid_edge%0d got %0d want %0d", i, i < pe.size() ? pe[i] : -1, exp_q[i]);
      else passed++;
    end
  endtask
  initial begin
    test_reset;
    test_single_press;
    test_repeat;
    test_no_repeat;
    test_bounce;
    test_release_bounce;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
